// File: rtl/io_input_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// io_input_conditioner_pkg
// Shared constants for the board input conditioner.
//   - DEFAULT_DB_CYCLES: debounce window derived from the board clock.
//   - KEY_DB_LSB / key_tog_lsb(): field offsets inside in_port1.
// -----------------------------------------------------------------------------
package io_input_conditioner_pkg;

    localparam int CLK_FREQ_HZ       = 50_000_000;
    localparam int DB_TIME_MS        = 5;
    localparam int DEFAULT_DB_CYCLES = (CLK_FREQ_HZ / 1000) * DB_TIME_MS;
    localparam int DEFAULT_CNT_W     = 18;

    localparam int PORT_W     = 32;
    localparam int KEY_DB_LSB = 0;

    // Toggle field sits directly above the debounced key levels.
    function automatic int key_tog_lsb(input int key_w);
        return KEY_DB_LSB + key_w;
    endfunction

endpackage

// File: rtl/io_input_conditioner_debounce_bit.sv
// -----------------------------------------------------------------------------
// debounce_bit
// One raw pin -> 2-flop synchronizer -> consecutive-sample debounce.
// Ports:
//   clock, resetn   : clock, synchronous active-low reset
//   raw_i           : asynchronous pin level (already polarity-corrected)
//   level_o         : accepted stable level (registered)
//   rise_o          : one-cycle pulse, high the cycle after level_o rises
//   rise_next_o     : rise_o's next-state; lets the parent update state on
//                     the same edge that level_o rises
// -----------------------------------------------------------------------------
module debounce_bit
    import io_input_conditioner_pkg::*;
#(
    parameter int DB_CYCLES = DEFAULT_DB_CYCLES,
    parameter int CNT_W     = DEFAULT_CNT_W,
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clock,
    input  logic resetn,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic rise_next_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic             s1_q, s2_q;
    logic             stable_q, stable_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any sample that agrees with the stable level clears the count, so a
    // reversal mid-count gets no partial credit.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (s2_q != stable_q) begin
            if (cnt_q == CNT_MAX) stable_d = s2_q;
            else                  cnt_d    = cnt_q + CNT_W'(1);
        end
        rise_d = stable_d & ~stable_q;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            s1_q     <= RESET_VAL;
            s2_q     <= RESET_VAL;
            stable_q <= RESET_VAL;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
        end else begin
            s1_q     <= raw_i;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
        end
    end

    assign level_o     = stable_q;
    assign rise_o      = rise_q;
    assign rise_next_o = rise_d;

endmodule

// File: rtl/io_input_conditioner.sv
// -----------------------------------------------------------------------------
// io_input_conditioner
// Cleans raw board switches and push-keys into synchronous words for the
// CPU's in_port0 / in_port1.
// Ports:
//   clock, resetn : clock, synchronous active-low reset
//   sw_raw        : asynchronous slide-switch pins
//   key_raw       : asynchronous push-key pins
//   in_port0      : {0, sw_db}
//   in_port1      : {0, key_tog, key_db}
//   key_press     : one-cycle pulse per accepted key press
// -----------------------------------------------------------------------------
module io_input_conditioner
    import io_input_conditioner_pkg::*;
#(
    parameter int SW_W           = 10,
    parameter int KEY_W          = 4,
    parameter int DB_CYCLES      = DEFAULT_DB_CYCLES,
    parameter int CNT_W          = DEFAULT_CNT_W,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [SW_W-1:0]   sw_raw,
    input  logic [KEY_W-1:0]  key_raw,
    output logic [PORT_W-1:0] in_port0,
    output logic [PORT_W-1:0] in_port1,
    output logic [KEY_W-1:0]  key_press
);

    localparam int KEY_TOG_LSB = key_tog_lsb(KEY_W);

    logic [KEY_W-1:0] key_in;
    logic [KEY_W-1:0] key_db, key_rise_next;
    logic [KEY_W-1:0] key_tog_q, key_tog_d;
    logic [SW_W-1:0]  sw_db;
    logic [SW_W-1:0]  sw_rise_unused, sw_rise_next_unused;

    // Internally 1 always means pressed; inversion happens before the
    // synchronizer so the sync flops' reset value means "released".
    assign key_in = KEY_ACTIVE_LOW ? ~key_raw : key_raw;

    for (genvar i = 0; i < SW_W; i++) begin : g_sw
        debounce_bit #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W),
            .RESET_VAL (1'b0)
        ) u_db (
            .clock       (clock),
            .resetn      (resetn),
            .raw_i       (sw_raw[i]),
            .level_o     (sw_db[i]),
            .rise_o      (sw_rise_unused[i]),
            .rise_next_o (sw_rise_next_unused[i])
        );
    end

    for (genvar i = 0; i < KEY_W; i++) begin : g_key
        debounce_bit #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W),
            .RESET_VAL (1'b0)
        ) u_db (
            .clock       (clock),
            .resetn      (resetn),
            .raw_i       (key_in[i]),
            .level_o     (key_db[i]),
            .rise_o      (key_press[i]),
            .rise_next_o (key_rise_next[i])
        );
    end

    // Toggle flips on the edge the debounced level rises, the same edge
    // that raises key_press.
    assign key_tog_d = key_tog_q ^ key_rise_next;

    always_ff @(posedge clock) begin
        if (!resetn) key_tog_q <= '0;
        else         key_tog_q <= key_tog_d;
    end

    always_comb begin
        in_port0 = '0;
        in_port0[SW_W-1:0] = sw_db;
        in_port1 = '0;
        in_port1[KEY_DB_LSB  +: KEY_W] = key_db;
        in_port1[KEY_TOG_LSB +: KEY_W] = key_tog_q;
    end

endmodule

// File: tb/tb_io_input_conditioner.sv
module tb_io_input_conditioner;

    localparam int SW_W  = 10;
    localparam int KEY_W = 4;
    localparam int DB    = 4;
    localparam int NB    = SW_W + KEY_W;

    logic              clock;
    logic              resetn;
    logic [SW_W-1:0]   sw_raw;
    logic [KEY_W-1:0]  key_raw;
    logic [31:0]       in_port0, in_port1;
    logic [KEY_W-1:0]  key_press;

    int n_cmp = 0;
    int n_bad = 0;

    io_input_conditioner #(
        .SW_W(SW_W), .KEY_W(KEY_W), .DB_CYCLES(DB), .CNT_W(3), .KEY_ACTIVE_LOW(1'b1)
    ) dut (
        .clock(clock), .resetn(resetn), .sw_raw(sw_raw), .key_raw(key_raw),
        .in_port0(in_port0), .in_port1(in_port1), .key_press(key_press)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    // Each bit sees its pin through a two-sample delay line; the accepted
    // level flips once the last DB delayed samples all disagree with it.
    logic [NB-1:0]    m_s1, m_s2, m_st;
    logic [DB-1:0]    m_win [NB];
    int               m_nv  [NB];
    logic [KEY_W-1:0] m_press, m_tog;

    task model_edge(input logic r, input logic [SW_W-1:0] s, input logic [KEY_W-1:0] k);
        if (!r) begin
            m_s1 = '0; m_s2 = '0; m_st = '0; m_press = '0; m_tog = '0;
            for (int b = 0; b < NB; b++) begin m_win[b] = '0; m_nv[b] = 0; end
        end else begin
            m_press = '0;
            for (int b = 0; b < NB; b++) begin
                m_win[b] = {m_win[b][DB-2:0], m_s2[b]};
                if (m_nv[b] < DB) m_nv[b]++;
                if (m_nv[b] == DB && m_win[b] == {DB{~m_st[b]}}) begin
                    m_st[b] = ~m_st[b];
                    if (b >= SW_W && m_st[b]) begin
                        m_press[b-SW_W] = 1'b1;
                        m_tog[b-SW_W]   = ~m_tog[b-SW_W];
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = {~k, s};
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", nm, act, exp);
        end
    endtask

    logic [SW_W-1:0]  cur_sw;
    logic [KEY_W-1:0] cur_key;

    task automatic step(input logic r, input logic [SW_W-1:0] s, input logic [KEY_W-1:0] k);
        resetn = r; sw_raw = s; key_raw = k;
        @(posedge clock);
        model_edge(r, s, k);
        #1;
        chk("model_in_port0", in_port0, {22'b0, m_st[SW_W-1:0]});
        chk("model_in_port1", in_port1, {24'b0, m_tog, m_st[NB-1:SW_W]});
        chk("model_key_press", {28'b0, key_press}, {28'b0, m_press});
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) step(1'b1, cur_sw, cur_key);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic             rst;
        logic [SW_W-1:0]  sw;
        logic [KEY_W-1:0] key;
        logic [31:0]      p0;
        logic [31:0]      p1;
        logic [KEY_W-1:0] kp;
    } vec_t;

    vec_t vt[$];

    task automatic add(input int n, input logic r, input logic [SW_W-1:0] s, input logic [KEY_W-1:0] k,
                       input logic [31:0] p0, input logic [31:0] p1, input logic [KEY_W-1:0] kp);
        vec_t v;
        v.rst = r; v.sw = s; v.key = k; v.p0 = p0; v.p1 = p1; v.kp = kp;
        for (int i = 0; i < n; i++) vt.push_back(v);
    endtask

    initial begin
        int first, pulses, nz;
        logic [KEY_W-1:0] pv;

        // reset with everything asserted at the pins
        add(3,  1'b0, 10'h3FF, 4'h0, 32'h0,   32'h0,  4'h0);
        // switch latency: visible after edge 6
        add(5,  1'b1, 10'h2A5, 4'hF, 32'h0,   32'h0,  4'h0);
        add(2,  1'b1, 10'h2A5, 4'hF, 32'h2A5, 32'h0,  4'h0);
        // key 2 pressed (pin low) and held 20 cycles
        add(5,  1'b1, 10'h2A5, 4'hB, 32'h2A5, 32'h0,  4'h0);
        add(1,  1'b1, 10'h2A5, 4'hB, 32'h2A5, 32'h44, 4'h4);
        add(14, 1'b1, 10'h2A5, 4'hB, 32'h2A5, 32'h44, 4'h0);

        foreach (vt[i]) begin
            step(vt[i].rst, vt[i].sw, vt[i].key);
            chk($sformatf("vec%0d_in_port0", i), in_port0, vt[i].p0);
            chk($sformatf("vec%0d_in_port1", i), in_port1, vt[i].p1);
            chk($sformatf("vec%0d_key_press", i), {28'b0, key_press}, {28'b0, vt[i].kp});
        end
        cur_sw = 10'h2A5; cur_key = 4'hB;

        // glitch: bit 0 high for 3 cycles is rejected, then a steady level
        // needs the full latency again
        cur_sw = 10'h2A4; hold(8);
        first = 0;
        cur_sw = 10'h2A5; for (int i = 0; i < 3; i++) begin step(1'b1, cur_sw, cur_key); if (in_port0[0]) first = 1; end
        cur_sw = 10'h2A4; for (int i = 0; i < 8; i++) begin step(1'b1, cur_sw, cur_key); if (in_port0[0]) first = 1; end
        chk("glitch_no_rise", first, 0);
        first = -1;
        cur_sw = 10'h2A5;
        for (int e = 1; e <= 12; e++) begin
            step(1'b1, cur_sw, cur_key);
            if (first < 0 && in_port0[0]) first = e;
        end
        chk("glitch_full_latency", first, 6);

        // release key 2: no pulse; press again: one pulse, toggle back to 0
        pulses = 0;
        cur_key = 4'hF;
        for (int i = 0; i < 10; i++) begin step(1'b1, cur_sw, cur_key); if (key_press != 0) pulses++; end
        chk("release_no_pulse", pulses, 0);
        chk("release_key_db", in_port1[2], 1'b0);
        cur_key = 4'hB;
        for (int i = 0; i < 12; i++) begin step(1'b1, cur_sw, cur_key); if (key_press[2]) pulses++; end
        chk("repress_pulses", pulses, 1);
        chk("repress_tog2", in_port1[6], 1'b0);
        cur_key = 4'hF; hold(8);

        // simultaneous press of keys 0 and 3
        nz = 0; pv = '0;
        cur_key = 4'b0110;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, cur_sw, cur_key);
            if (key_press != 0) begin nz++; pv = key_press; end
        end
        chk("simul_press_val", {28'b0, pv}, 32'h9);
        chk("simul_press_cycles", nz, 1);
        chk("simul_tog", {28'b0, in_port1[7:4]}, 32'h9);
        cur_key = 4'hF; hold(8);

        // key 1 held through resets: mid-count and after acceptance
        cur_key = 4'b1101;
        hold(3);
        step(1'b0, cur_sw, cur_key);
        chk("rst1_in_port0", in_port0, 32'h0);
        chk("rst1_in_port1", in_port1, 32'h0);
        chk("rst1_key_press", {28'b0, key_press}, 32'h0);
        first = -1; pulses = 0;
        for (int e = 1; e <= 15; e++) begin
            step(1'b1, cur_sw, cur_key);
            if (key_press[1]) begin pulses++; if (first < 0) first = e; end
        end
        chk("rst1_press_latency", first, 6);
        chk("rst1_press_count", pulses, 1);
        step(1'b0, cur_sw, cur_key);
        chk("rst2_in_port0", in_port0, 32'h0);
        chk("rst2_in_port1", in_port1, 32'h0);
        chk("rst2_key_press", {28'b0, key_press}, 32'h0);
        first = -1;
        for (int e = 1; e <= 15; e++) begin
            step(1'b1, cur_sw, cur_key);
            if (first < 0 && key_press[1]) first = e;
        end
        chk("rst2_press_latency", first, 6);

        // randomized: sparse pin flips (some short enough to be glitches)
        // and occasional resets, all checked against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(5) == 0) cur_sw[$urandom_range(SW_W-1)] ^= 1'b1;
            if ($urandom_range(5) == 0) cur_key[$urandom_range(KEY_W-1)] ^= 1'b1;
            step(($urandom_range(99) != 0), cur_sw, cur_key);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/io_input_conditioner.md
Name: io_input_conditioner

Overview:
- Upstream feeder for the computer's data-memory I/O read path: turns raw board switches and push-keys into clean, synchronous words for in_port0 and in_port1.
- Each raw bit gets a 2-flop synchronizer and a per-bit debounce counter. Each key also gets a press-edge pulse and a press-toggle latch.
- Sits between board pins and the in_port0/in_port1 inputs of the computer top, in the same clock domain as the CPU.

Parameters:
- SW_W, 10, number of slide-switch inputs (1..32).
- KEY_W, 4, number of push-key inputs (1..16).
- DB_CYCLES, 250000, consecutive stable samples needed to accept a new level (5 ms at 50 MHz); must be >= 2.
- CNT_W, 18, debounce counter width; must satisfy 2**CNT_W >= DB_CYCLES.
- KEY_ACTIVE_LOW, 1, 1 = raw key pin reads 0 when pressed (inverted before synchronizing).

Ports:
- clock, in, 1, system clock; all state updates on the rising edge.
- resetn, in, 1, synchronous active-low reset; sampled on the rising edge of clock.
- sw_raw, in, SW_W, asynchronous slide-switch pins.
- key_raw, in, KEY_W, asynchronous push-key pins.
- in_port0, out, 32, {zeros, sw_db[SW_W-1:0]}.
- in_port1, out, 32, {zeros, key_tog[KEY_W-1:0], key_db[KEY_W-1:0]}, with key_db in bits [KEY_W-1:0] and key_tog in bits [2*KEY_W-1:KEY_W].
- key_press, out, KEY_W, one-cycle pulse per key on each accepted press.

Behaviour:
- Reset (resetn=0 at a rising edge):
  - All sync flops, counters, stable levels (sw_db, key_db), key_tog and key_press go to 0 on that edge.
  - Key sync flops reset to "released", i.e. 0 after any polarity inversion.
  - in_port0, in_port1 and key_press read 0 the cycle after.
- Polarity: with KEY_ACTIVE_LOW=1, key_raw is inverted before the first sync flop. Internally 1 = pressed everywhere.
- Synchronizer: s1 <= raw, s2 <= s1 on every edge. Only s2 is used downstream.
- Debounce, per bit, with state stable and cnt:
  - s2 == stable: cnt <= 0.
  - s2 != stable and cnt == DB_CYCLES-1: stable <= s2, cnt <= 0.
  - s2 != stable otherwise: cnt <= cnt+1.
- Latency: a raw level held steady first appears on the outputs at the (DB_CYCLES+2)th rising edge, counting the first edge that captures it into s1 as edge 1.
- Glitch rejection: a raw pulse shorter than DB_CYCLES cycles (after sync) never changes stable, and cnt returns to 0.
- Any reversal of s2 mid-count resets cnt; there is no partial credit.
- key_press[i] is 1 for exactly the one cycle after key_db[i] goes 0->1. No pulse is generated on release.
- key_tog[i] flips on the same edge that key_press[i] is asserted, i.e. when key_db[i] rises.
- Outputs are driven directly from registers. There is no combinational path from raw pins to outputs.
- Bits are fully independent. Simultaneous changes on several bits are each debounced separately, and several key_press bits may assert in the same cycle.
- Reset mid-count: the counter is discarded.
- Key held through reset: after reset it re-debounces from "released", so it yields one key_press and one toggle DB_CYCLES+2 edges after resetn returns to 1.
- Switch held high through reset: sw_db rises again after the same latency.
- Unused upper bits of in_port0/in_port1 are constant 0.

Decomposition:
- Shared package/include holds:
  - default DB_CYCLES value and the clock-frequency constant used to derive it;
  - the in_port1 field offsets (KEY_DB_LSB=0, KEY_TOG_LSB=KEY_W).
- One natural sub-module: debounce_bit (params DB_CYCLES, CNT_W, RESET_VAL).
  - Contains the 2-flop sync, counter and stable register; outputs the stable level and a one-cycle rise pulse.
  - Instantiated SW_W + KEY_W times via generate.
- Top level adds the key polarity inversion, toggle latches and port packing.

Test Plan (all with DB_CYCLES=4, SW_W=10, KEY_W=4, KEY_ACTIVE_LOW=1):
- Reset: hold resetn=0 for 3 edges with sw_raw=10'h3FF and key_raw=4'h0 -> in_port0=0, in_port1=0, key_press=0 while in reset.
- Switch latency: from reset, sw_raw=10'h2A5 applied before edge 1 -> in_port0 stays 0 through edge 5 and reads 32'h000002A5 after edge 6.
- Glitch: sw_raw[0] goes high for 3 cycles, then back to 0 -> in_port0[0] never rises and the bit-0 counter ends at 0.
- Key press/toggle: key_raw[2] goes 1->0 and is held 20 cycles ->
  - after edge 6: in_port1[2]=1;
  - key_press=4'b0100 for exactly one cycle;
  - in_port1[6]=1.
  - Release, then press again -> in_port1[6] returns to 0 and one more pulse is seen.
- Simultaneous: key_raw[0] and key_raw[3] pressed on the same cycle -> key_press=4'b1001 in one cycle and in_port1[7:4]=4'b1001.
- Reset mid-operation: key_raw[1] held pressed, resetn pulsed low for 1 edge mid-count and again after acceptance -> all outputs 0 after each reset edge; key_press[1] pulses once, 6 edges after resetn returns to 1.
